// File: rtl/pll_reset_supervisor.sv
// PLL supervisor and staged reset generator: drives PLL reset/power-down, filters
// the synchronised LOCKED, releases domain resets in order and re-sequences on faults.
module pll_reset_supervisor #(
  parameter int NUM_DOMAINS         = 3,
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_FILTER_CYCLES  = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STAGE_DELAY_CYCLES  = 256,
  parameter int MAX_RETRIES         = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   pll_locked_i,
  input  logic                   pwrdwn_req_i,
  input  logic                   clear_i,
  output logic                   pll_rst_o,
  output logic                   pll_pwrdwn_o,
  output logic [NUM_DOMAINS-1:0] domain_rst_o,
  output logic                   ready_o,
  output logic                   fail_o,
  output logic [3:0]             retry_count_o,
  output logic [7:0]             lock_loss_count_o
);

  localparam int REL_CYCLES = STAGE_DELAY_CYCLES * NUM_DOMAINS;
  localparam int CNT_MAX =
    (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES)
      ? ((RST_PULSE_CYCLES > REL_CYCLES) ? RST_PULSE_CYCLES : REL_CYCLES)
      : ((LOCK_TIMEOUT_CYCLES > REL_CYCLES) ? LOCK_TIMEOUT_CYCLES : REL_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX) + 1;
  localparam int FLT_W = $clog2(LOCK_FILTER_CYCLES) + 1;

  localparam logic [CNT_W-1:0] RST_LIM   = CNT_W'(RST_PULSE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LIM   = CNT_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] REL_LIM   = CNT_W'(REL_CYCLES);
  localparam logic [FLT_W-1:0] FLT_LIM   = FLT_W'(LOCK_FILTER_CYCLES);
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4,
    S_PWRDN     = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [FLT_W-1:0]         flt_q, flt_d;
  logic [3:0]               retry_q, retry_d;
  logic [7:0]               llc_q, llc_d;
  logic [1:0]               sync_q;
  logic                     lk;
  logic                     lock_loss;
  logic [NUM_DOMAINS-1:0]   dom_d;

  logic                     pll_rst_q, pll_pwrdwn_q, ready_q, fail_q;
  logic [NUM_DOMAINS-1:0]   dom_q;

  assign lk = sync_q[1];

  // Next state and counters; power-down overrides everything else.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    flt_d     = '0;
    retry_d   = retry_q;
    llc_d     = llc_q;
    lock_loss = 1'b0;
    if (pwrdwn_req_i) begin
      state_d = S_PWRDN;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          if (cnt_d == RST_LIM) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          flt_d = lk ? flt_q + FLT_W'(1) : '0;
          if (flt_d == FLT_LIM) begin
            state_d = S_RELEASE;
          end else if (cnt_d == TMO_LIM) begin
            retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
            state_d = (retry_d == RETRY_LIM) ? S_FAIL : S_PLL_RST;
          end
        end
        S_RELEASE: begin
          if (!lk) lock_loss = 1'b1;
          else if (cnt_d == REL_LIM) state_d = S_RUN;
        end
        S_RUN: begin
          if (!lk) lock_loss = 1'b1;
        end
        S_FAIL: begin
          if (clear_i) begin
            state_d = S_PLL_RST;
            retry_d = '0;
          end
        end
        S_PWRDN: begin
          state_d = S_PLL_RST;
          retry_d = '0;
        end
        default: state_d = S_PLL_RST;
      endcase
    end
    if (lock_loss) begin
      state_d = S_PLL_RST;
      llc_d   = (llc_q == 8'hFF) ? llc_q : llc_q + 8'd1;
    end
    if (state_d != state_q) begin
      cnt_d = '0;
      flt_d = '0;
    end
    if (state_d == S_RUN) retry_d = '0;
  end

  // Domain k is released once the RELEASE dwell reaches STAGE_DELAY*(k+1).
  always_comb begin
    dom_d = '1;
    if (state_d == S_RUN) begin
      dom_d = '0;
    end else if (state_d == S_RELEASE) begin
      for (int k = 0; k < NUM_DOMAINS; k++) begin
        dom_d[k] = (int'(cnt_d) < STAGE_DELAY_CYCLES * (k + 1));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_PLL_RST;
      cnt_q        <= '0;
      flt_q        <= '0;
      retry_q      <= '0;
      llc_q        <= '0;
      sync_q       <= '0;
      pll_rst_q    <= 1'b1;
      pll_pwrdwn_q <= 1'b0;
      dom_q        <= '1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flt_q        <= flt_d;
      retry_q      <= retry_d;
      llc_q        <= llc_d;
      sync_q       <= {sync_q[0], pll_locked_i};
      pll_rst_q    <= (state_d == S_PLL_RST) || (state_d == S_FAIL) || (state_d == S_PWRDN);
      pll_pwrdwn_q <= (state_d == S_PWRDN);
      dom_q        <= dom_d;
      ready_q      <= (state_d == S_RUN);
      fail_q       <= (state_d == S_FAIL);
    end
  end

  assign pll_rst_o         = pll_rst_q;
  assign pll_pwrdwn_o      = pll_pwrdwn_q;
  assign domain_rst_o      = dom_q;
  assign ready_o           = ready_q;
  assign fail_o            = fail_q;
  assign retry_count_o     = retry_q;
  assign lock_loss_count_o = llc_q;

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Bench for pll_reset_supervisor: randomized scenarios, timestamp-based reference
// model producing an expected output vector per cycle, decoupled monitor.
module tb_pll_reset_supervisor;

  localparam int N  = 3;
  localparam int RP = 4;
  localparam int LF = 8;
  localparam int TO = 100;
  localparam int S  = 16;
  localparam int MR = 2;

  localparam int P_RST = 0, P_WAIT = 1, P_REL = 2, P_RUN = 3, P_FAIL = 4, P_PWRDN = 5;

  logic         clk_i, rst_n_i, pll_locked_i, pwrdwn_req_i, clear_i;
  logic         pll_rst_o, pll_pwrdwn_o, ready_o, fail_o;
  logic [N-1:0] domain_rst_o;
  logic [3:0]   retry_count_o;
  logic [7:0]   lock_loss_count_o;

  pll_reset_supervisor #(
    .NUM_DOMAINS(N), .RST_PULSE_CYCLES(RP), .LOCK_FILTER_CYCLES(LF),
    .LOCK_TIMEOUT_CYCLES(TO), .STAGE_DELAY_CYCLES(S), .MAX_RETRIES(MR)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pll_locked_i(pll_locked_i),
    .pwrdwn_req_i(pwrdwn_req_i), .clear_i(clear_i), .pll_rst_o(pll_rst_o),
    .pll_pwrdwn_o(pll_pwrdwn_o), .domain_rst_o(domain_rst_o), .ready_o(ready_o),
    .fail_o(fail_o), .retry_count_o(retry_count_o), .lock_loss_count_o(lock_loss_count_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // scoreboard state
  logic [18:0] exp_q[$];
  logic [18:0] act_v;
  int vectors     = 0;
  int miscompares = 0;

  assign act_v = {pll_rst_o, pll_pwrdwn_o, domain_rst_o, ready_o, fail_o,
                  retry_count_o, lock_loss_count_o};

  // reference model: phase plus entry timestamp, all timing from cycle arithmetic
  int cyc = 0, ph = P_RST, t_enter = 0, ones_from = -1, m_retry = 0, m_llc = 0;
  bit m_s1 = 1'b0, m_s2 = 1'b0;

  function automatic void model_reset();
    ph = P_RST; t_enter = cyc; ones_from = -1; m_retry = 0; m_llc = 0;
    m_s1 = 1'b0; m_s2 = 1'b0;
  endfunction

  function automatic void model_step();
    int nxt;
    bit lk, loss;
    lk = m_s2; m_s2 = m_s1; m_s1 = pll_locked_i;
    nxt = ph; loss = 1'b0;
    if (pwrdwn_req_i) nxt = P_PWRDN;
    else begin
      case (ph)
        P_RST:  if (cyc - t_enter == RP) nxt = P_WAIT;
        P_WAIT: begin
          if (!lk) ones_from = -1;
          else if (ones_from < 0) ones_from = cyc;
          if (lk && (cyc - ones_from + 1 == LF)) nxt = P_REL;
          else if (cyc - t_enter == TO) begin
            if (m_retry < 15) m_retry++;
            nxt = (m_retry == MR) ? P_FAIL : P_RST;
          end
        end
        P_REL:  if (!lk) loss = 1'b1; else if (cyc - t_enter == S * N) nxt = P_RUN;
        P_RUN:  if (!lk) loss = 1'b1;
        P_FAIL: if (clear_i) begin nxt = P_RST; m_retry = 0; end
        default: begin nxt = P_RST; m_retry = 0; end
      endcase
    end
    if (loss) begin
      nxt = P_RST;
      if (m_llc < 255) m_llc++;
    end
    if (nxt != ph) begin ph = nxt; t_enter = cyc; ones_from = -1; end
    if (ph == P_RUN) m_retry = 0;
  endfunction

  function automatic logic [18:0] exp_vec();
    logic [2:0] dom;
    dom = 3'b111;
    if (ph == P_RUN) dom = 3'b000;
    else if (ph == P_REL)
      for (int k = 0; k < N; k++) if (cyc - t_enter >= S * (k + 1)) dom[k] = 1'b0;
    return {(ph == P_RST) || (ph == P_FAIL) || (ph == P_PWRDN), ph == P_PWRDN, dom,
            ph == P_RUN, ph == P_FAIL, 4'(m_retry), 8'(m_llc)};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    cyc++;
    if (rst_n_i) model_step(); else model_reset();
    exp_q.push_back(exp_vec());
    @(negedge clk_i);
  endtask

  task automatic run_until(input int target, input int budget);
    int i;
    i = 0;
    while (ph != target && i < budget) begin tick(); i++; end
    vectors++;
    if (ph != target) begin
      miscompares++;
      $display("FAIL phase_wait: reached phase %0d, required phase %0d within %0d cycles",
               ph, target, budget);
    end
  endtask

  // monitor: compares every expected vector against the DUT outputs
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge clk_i or negedge rst_n_i);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (act_v !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t cyc=%0d act=%05h exp=%05h (rst,pwd,dom,rdy,fail,retry,llc)",
                   $time, cyc, act_v, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    int r;
    pll_locked_i = 1'b0; pwrdwn_req_i = 1'b0; clear_i = 1'b0; rst_n_i = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n_i = 1'b1;

    // nominal bring-up
    repeat ($urandom_range(15, 25)) tick();
    pll_locked_i = 1'b1;
    run_until(P_RUN, 200);
    repeat ($urandom_range(5, 15)) tick();

    // lock loss in RUN
    pll_locked_i = 1'b0;
    run_until(P_WAIT, 20);

    // filter glitch inside WAIT_LOCK
    repeat ($urandom_range(0, 5)) tick();
    pll_locked_i = 1'b1; repeat (5) tick();
    pll_locked_i = 1'b0; tick();
    pll_locked_i = 1'b1;
    run_until(P_RUN, 200);
    repeat (5) tick();

    // timeout / fail / clear
    pll_locked_i = 1'b0;
    run_until(P_FAIL, 400);
    repeat ($urandom_range(3, 10)) tick();
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    repeat (10) tick();

    // power-down after domain 0 release
    pll_locked_i = 1'b1;
    run_until(P_REL, 200);
    repeat (S + $urandom_range(0, S - 2)) tick();
    pwrdwn_req_i = 1'b1;
    repeat ($urandom_range(2, 8)) tick();
    pwrdwn_req_i = 1'b0;
    run_until(P_RUN, 200);
    repeat (5) tick();

    // async reset in RUN, asserted between clock edges
    #2 rst_n_i = 1'b0;
    model_reset();
    exp_q.push_back(exp_vec());
    repeat (3) tick();
    rst_n_i = 1'b1;
    run_until(P_RUN, 200);

    // randomized mix of lock toggles, power-down and clear pulses
    repeat (1500) begin
      r = $urandom_range(0, 199);
      if (r < 4) pll_locked_i = ~pll_locked_i;
      if (r == 199) pwrdwn_req_i = ~pwrdwn_req_i;
      clear_i = (r >= 100 && r < 103);
      tick();
    end
    clear_i = 1'b0; pwrdwn_req_i = 1'b0;
    repeat (3) tick();
    @(negedge clk_i);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
